sextium_io_port: RTL and testbench
==================================

SEXTIUM_IO_PORT -- requirements
Module: sextium_io_port

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entries per FIFO; legal values 2, 4, 8.
REQ-002 SHALL have parameter IO_BASE, default 16'h0000, base I/O address; bit 0 of IO_BASE is 0.
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low; low at a rising edge resets the block.
REQ-005 addr_bus  input  16  address from core, qualified by io_read/io_write.
REQ-006 mem_bus  inout  16  shared data bus; driven only as REQ-013 states, else high-Z.
REQ-007 io_read  input  1  core I/O read strobe.
REQ-008 io_write  input  1  core I/O write strobe.
REQ-009 in_data  input  16  external input word; in_valid input 1; in_ready output 1.
REQ-010 out_data  output  16  external output word; out_valid output 1; out_ready input 1.
REQ-011 err  output  1  OR of sticky underflow and overflow flags.

Function
REQ-012 Decode: sel_data = (addr_bus == IO_BASE); sel_stat = (addr_bus == IO_BASE+1); other addresses ignored, bus not driven.
REQ-013 mem_bus driven combinationally while io_read=1, io_write=0, and sel_data or sel_stat: data = input FIFO head (16'h0000 if empty); status = status word.
REQ-014 Status word: [0] input nonempty; [1] output not full; [2] underflow; [3] overflow; [7:4] input count; [11:8] output count; [15:12] zero.
REQ-015 Strobe edge detect: registered io_read_q/io_write_q; access acts once, at the first rising edge where strobe=1 and its _q=0; a strobe held N cycles acts once.
REQ-016 io_read and io_write both 1: no action, no drive, no flag change; _q registers still update.
REQ-017 Data read action: input FIFO nonempty -> pop head; empty -> set underflow, no pointer change.
REQ-018 Data write action: output count < DEPTH before the edge -> push mem_bus; else set overflow, word dropped.
REQ-019 Status write action: clears underflow and overflow, regardless of data value; status read has no side effect.
REQ-020 Input FIFO: in_ready = (input count < DEPTH); push when in_valid & in_ready at edge.
REQ-021 Output FIFO: out_valid = (output count != 0); out_data = head; pop when out_valid & out_ready.
REQ-022 Same-edge push and pop on one FIFO both occur; count unchanged; full-FIFO push is decided on pre-edge count (no bypass).
REQ-023 Pointers are log2(DEPTH) bits, wrap modulo DEPTH; counts 0..DEPTH, never exceed DEPTH or go below 0.
REQ-024 Latency: external push visible on bus/status next cycle; core write visible on out_data/out_valid next cycle.
REQ-025 FIFO storage is plain registers; no reset of contents required.

Reset
REQ-026 On reset low at an edge: both counts and pointers 0, underflow=0, overflow=0, io_read_q=io_write_q=0.
REQ-027 Outputs during/after reset: in_ready=1, out_valid=0, err=0, out_data=don't-care, mem_bus high-Z unless REQ-013 read.
REQ-028 Reset mid-access: pending strobe edge discarded; strobe still high after reset deasserts does not act until it falls and rises again.

Verification
REQ-029 Push 16'h1234, 16'hABCD via in_valid; io_read at IO_BASE twice (separate pulses) -> bus 16'h1234 then 16'hABCD; status then 16'h0002.
REQ-030 io_write 16'h0005..16'h000C (8 words, DEPTH=8), out_ready=0 -> status [11:8]=8, [1]=0; 9th write -> overflow=1, err=1; drain with out_ready=1 yields 5..C in order.
REQ-031 io_read IO_BASE with input empty -> bus 16'h0000, underflow=1, status 16'h0006; io_write IO_BASE+1 -> status 16'h0002, err=0.
REQ-032 io_read held 4 cycles with 3 words queued -> exactly one pop; input count 3 -> 2.
REQ-033 Output FIFO full, out_ready=1 and io_write on same edge -> overflow=1, count 8 -> 7; input full, in_valid=1 -> in_ready=0, no push.
REQ-034 Fill both FIFOs with 3 words, set overflow, reset low one edge -> status 16'h0002, in_ready=1, out_valid=0, err=0.

Source files
------------

// File: rtl/sextium_io_port.sv
// Memory-mapped I/O port for the Sextium core: one data address backed by an
// input FIFO (read side) and an output FIFO (write side), plus a status word.
module sextium_io_port #(
  parameter int          DEPTH   = 8,
  parameter logic [15:0] IO_BASE = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr_bus,
  inout  wire  [15:0] mem_bus,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err
);

  localparam int             AW        = $clog2(DEPTH);
  localparam int             CW        = AW + 1;
  localparam logic [CW-1:0]  FULL      = CW'(DEPTH);
  localparam logic [15:0]    STAT_ADDR = IO_BASE + 16'd1;

  logic [15:0]   in_mem  [DEPTH];
  logic [15:0]   out_mem [DEPTH];
  logic [AW-1:0] in_wr_ptr, in_rd_ptr;
  logic [AW-1:0] out_wr_ptr, out_rd_ptr;
  logic [CW-1:0] in_count, out_count;
  logic          underflow, overflow;
  logic          io_read_q, io_write_q;
  logic          read_block, write_block;

  logic          sel_data, sel_stat;
  logic          rd_edge, wr_edge;
  logic          in_push, in_pop, out_push, out_pop;
  logic          set_under, set_over, clr_flags;
  logic [15:0]   status_word, in_head, bus_word;
  logic          bus_drive;

  assign sel_data = (addr_bus == IO_BASE);
  assign sel_stat = (addr_bus == STAT_ADDR);

  // A strobe acts only on its first cycle high; simultaneous read and write
  // is treated as a bus conflict and ignored. The block flags keep a strobe
  // that was already high across reset from acting until it is re-asserted.
  assign rd_edge = io_read  & ~io_write & ~io_read_q  & ~read_block;
  assign wr_edge = io_write & ~io_read  & ~io_write_q & ~write_block;

  assign in_ready  = (in_count < FULL);
  assign out_valid = (out_count != '0);
  assign out_data  = out_mem[out_rd_ptr];
  assign err       = underflow | overflow;

  assign in_push   = in_valid & in_ready;
  assign in_pop    = rd_edge & sel_data & (in_count != '0);
  assign set_under = rd_edge & sel_data & (in_count == '0);
  assign out_push  = wr_edge & sel_data & (out_count < FULL);
  assign set_over  = wr_edge & sel_data & (out_count == FULL);
  assign out_pop   = out_valid & out_ready;
  assign clr_flags = wr_edge & sel_stat;

  assign in_head     = in_mem[in_rd_ptr];
  assign status_word = {4'h0, 4'(out_count), 4'(in_count),
                        overflow, underflow, (out_count != FULL), (in_count != '0)};

  assign bus_drive = io_read & ~io_write & (sel_data | sel_stat);
  assign bus_word  = sel_data ? ((in_count != '0) ? in_head : 16'h0000) : status_word;
  assign mem_bus   = bus_drive ? bus_word : 16'hzzzz;

  always_ff @(posedge clock) begin
    if (in_push) begin
      in_mem[in_wr_ptr] <= in_data;
    end
    if (out_push) begin
      out_mem[out_wr_ptr] <= mem_bus;
    end
  end

  // Pointer and count bookkeeping; counts move only when exactly one of
  // push/pop happens, and the full/empty decisions above use pre-edge counts.
  always_ff @(posedge clock) begin
    if (!reset) begin
      in_wr_ptr   <= '0;
      in_rd_ptr   <= '0;
      in_count    <= '0;
      out_wr_ptr  <= '0;
      out_rd_ptr  <= '0;
      out_count   <= '0;
      underflow   <= 1'b0;
      overflow    <= 1'b0;
      io_read_q   <= 1'b0;
      io_write_q  <= 1'b0;
      read_block  <= io_read;
      write_block <= io_write;
    end else begin
      io_read_q  <= io_read;
      io_write_q <= io_write;
      if (!io_read) begin
        read_block <= 1'b0;
      end
      if (!io_write) begin
        write_block <= 1'b0;
      end

      if (in_push) begin
        in_wr_ptr <= in_wr_ptr + AW'(1);
      end
      if (in_pop) begin
        in_rd_ptr <= in_rd_ptr + AW'(1);
      end
      case ({in_push, in_pop})
        2'b10:   in_count <= in_count + CW'(1);
        2'b01:   in_count <= in_count - CW'(1);
        default: in_count <= in_count;
      endcase

      if (out_push) begin
        out_wr_ptr <= out_wr_ptr + AW'(1);
      end
      if (out_pop) begin
        out_rd_ptr <= out_rd_ptr + AW'(1);
      end
      case ({out_push, out_pop})
        2'b10:   out_count <= out_count + CW'(1);
        2'b01:   out_count <= out_count - CW'(1);
        default: out_count <= out_count;
      endcase

      if (clr_flags) begin
        underflow <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        if (set_under) begin
          underflow <= 1'b1;
        end
        if (set_over) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sextium_io_port.sv
// Directed self-checking bench for sextium_io_port with hand-computed
// expected bus, status and handshake values.
module tb_sextium_io_port;

  localparam logic [15:0] BASE = 16'h0040;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] addr_bus;
  wire  [15:0] mem_bus;
  logic        io_read, io_write;
  logic [15:0] in_data;
  logic        in_valid, in_ready;
  logic [15:0] out_data;
  logic        out_valid, out_ready;
  logic        err;
  logic        tb_drive;
  logic [15:0] tb_data;

  int compare_count = 0;
  int fail_count    = 0;

  assign mem_bus = tb_drive ? tb_data : 16'hzzzz;

  always #5 clock = ~clock;

  sextium_io_port #(.DEPTH(8), .IO_BASE(BASE)) dut (
    .clock(clock), .reset(reset), .addr_bus(addr_bus), .mem_bus(mem_bus),
    .io_read(io_read), .io_write(io_write),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err(err)
  );

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    compare_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] a,
                               input logic drive, input logic [15:0] d);
    io_read  = rd;
    io_write = wr;
    addr_bus = a;
    tb_drive = drive;
    tb_data  = d;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic core_read(input logic [15:0] a, output logic [15:0] d);
    applyStimulus(1'b1, 1'b0, a, 1'b0, 16'h0000);
    #1 d = mem_bus;
    step();
    applyStimulus(1'b0, 1'b0, BASE, 1'b0, 16'h0000);
    step();
  endtask

  task automatic core_write(input logic [15:0] a, input logic [15:0] d);
    applyStimulus(1'b0, 1'b1, a, 1'b1, d);
    step();
    applyStimulus(1'b0, 1'b0, BASE, 1'b0, 16'h0000);
    step();
  endtask

  task automatic peek_status(output logic [15:0] s);
    applyStimulus(1'b1, 1'b0, BASE + 16'd1, 1'b0, 16'h0000);
    #1 s = mem_bus;
    applyStimulus(1'b0, 1'b0, BASE, 1'b0, 16'h0000);
    #1;
  endtask

  task automatic push_input(input logic [15:0] d);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  logic [15:0] rd_val;
  logic [15:0] stat;

  initial begin
    applyStimulus(1'b0, 1'b0, BASE, 1'b0, 16'h0000);
    in_data   = 16'h0000;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b0;
    step();
    step();
    reset = 1'b1;

    checkOutput("reset_in_ready", {15'b0, in_ready}, 16'h0001);
    checkOutput("reset_out_valid", {15'b0, out_valid}, 16'h0000);
    checkOutput("reset_err", {15'b0, err}, 16'h0000);
    peek_status(stat);
    checkOutput("reset_status", stat, 16'h0002);

    // Two pushed words come back in order through the data address
    push_input(16'h1234);
    peek_status(stat);
    checkOutput("push1_status", stat, 16'h0013);
    push_input(16'hABCD);
    peek_status(stat);
    checkOutput("push2_status", stat, 16'h0023);
    core_read(BASE, rd_val);
    checkOutput("read1_data", rd_val, 16'h1234);
    core_read(BASE, rd_val);
    checkOutput("read2_data", rd_val, 16'hABCD);
    peek_status(stat);
    checkOutput("read_empty_status", stat, 16'h0002);

    // Underflow, then cleared by a status write
    core_read(BASE, rd_val);
    checkOutput("underflow_data", rd_val, 16'h0000);
    peek_status(stat);
    checkOutput("underflow_status", stat, 16'h0006);
    checkOutput("underflow_err", {15'b0, err}, 16'h0001);
    core_write(BASE + 16'd1, 16'hFFFF);
    peek_status(stat);
    checkOutput("clear_status", stat, 16'h0002);
    checkOutput("clear_err", {15'b0, err}, 16'h0000);

    // Fill output FIFO, overflow, then drain in order
    for (int i = 0; i < 8; i++) core_write(BASE, 16'(16'h0005 + i));
    peek_status(stat);
    checkOutput("out_full_status", stat, 16'h0800);
    checkOutput("out_head", out_data, 16'h0005);
    core_write(BASE, 16'h000D);
    peek_status(stat);
    checkOutput("overflow_status", stat, 16'h0808);
    checkOutput("overflow_err", {15'b0, err}, 16'h0001);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("drain_%0d", i), out_data, 16'(16'h0005 + i));
      step();
    end
    out_ready = 1'b0;
    checkOutput("drained_out_valid", {15'b0, out_valid}, 16'h0000);
    peek_status(stat);
    checkOutput("drained_status", stat, 16'h000A);
    core_write(BASE + 16'd1, 16'h0000);

    // A read held for four cycles pops exactly once
    push_input(16'h0100);
    push_input(16'h0200);
    push_input(16'h0300);
    peek_status(stat);
    checkOutput("three_status", stat, 16'h0033);
    applyStimulus(1'b1, 1'b0, BASE, 1'b0, 16'h0000);
    repeat (4) step();
    applyStimulus(1'b0, 1'b0, BASE, 1'b0, 16'h0000);
    step();
    peek_status(stat);
    checkOutput("held_read_status", stat, 16'h0023);
    core_read(BASE, rd_val);
    checkOutput("held_next_data", rd_val, 16'h0200);
    core_read(BASE, rd_val);
    checkOutput("held_last_data", rd_val, 16'h0300);

    // Foreign address and simultaneous strobes have no effect
    push_input(16'h5555);
    core_read(BASE + 16'd2, rd_val);
    peek_status(stat);
    checkOutput("foreign_addr_status", stat, 16'h0013);
    applyStimulus(1'b1, 1'b1, BASE, 1'b0, 16'h0000);
    step();
    applyStimulus(1'b0, 1'b0, BASE, 1'b0, 16'h0000);
    step();
    peek_status(stat);
    checkOutput("both_strobes_status", stat, 16'h0013);
    core_read(BASE, rd_val);
    checkOutput("after_both_data", rd_val, 16'h5555);

    // Write into a full output FIFO on the same edge it pops
    for (int i = 0; i < 8; i++) core_write(BASE, 16'(16'h0010 + i));
    applyStimulus(1'b0, 1'b1, BASE, 1'b1, 16'h0099);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, BASE, 1'b0, 16'h0000);
    peek_status(stat);
    checkOutput("full_pop_write_status", stat, 16'h070A);
    checkOutput("full_pop_write_head", out_data, 16'h0011);
    checkOutput("full_pop_write_err", {15'b0, err}, 16'h0001);
    step();
    core_write(BASE + 16'd1, 16'h0000);
    peek_status(stat);
    checkOutput("full_pop_clear_status", stat, 16'h0702);
    out_ready = 1'b1;
    repeat (7) step();
    out_ready = 1'b0;
    checkOutput("second_drain_valid", {15'b0, out_valid}, 16'h0000);

    // Input FIFO full: in_ready drops and extra word is not taken
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 16'(16'h0020 + i);
      step();
    end
    checkOutput("in_full_ready", {15'b0, in_ready}, 16'h0000);
    in_data = 16'hDEAD;
    step();
    in_valid = 1'b0;
    peek_status(stat);
    checkOutput("in_full_status", stat, 16'h0083);
    core_read(BASE, rd_val);
    checkOutput("in_full_head", rd_val, 16'h0020);
    peek_status(stat);
    checkOutput("in_after_pop_status", stat, 16'h0073);

    // Reset clears populated FIFOs and the sticky flag
    pulse_reset();
    for (int i = 0; i < 3; i++) push_input(16'(16'h0A00 + i));
    for (int i = 0; i < 9; i++) core_write(BASE, 16'(16'h0B00 + i));
    peek_status(stat);
    checkOutput("pre_reset_status", stat, 16'h0839);
    pulse_reset();
    peek_status(stat);
    checkOutput("post_reset_status", stat, 16'h0002);
    checkOutput("post_reset_in_ready", {15'b0, in_ready}, 16'h0001);
    checkOutput("post_reset_out_valid", {15'b0, out_valid}, 16'h0000);
    checkOutput("post_reset_err", {15'b0, err}, 16'h0000);

    // A read strobe held through reset must not act until re-asserted
    applyStimulus(1'b1, 1'b0, BASE, 1'b0, 16'h0000);
    pulse_reset();
    step();
    step();
    applyStimulus(1'b1, 1'b0, BASE + 16'd1, 1'b0, 16'h0000);
    #1 stat = mem_bus;
    checkOutput("held_through_reset_status", stat, 16'h0002);
    applyStimulus(1'b0, 1'b0, BASE, 1'b0, 16'h0000);
    step();
    checkOutput("held_through_reset_err", {15'b0, err}, 16'h0000);
    core_read(BASE, rd_val);
    peek_status(stat);
    checkOutput("rearmed_read_status", stat, 16'h0006);
    core_write(BASE + 16'd1, 16'h0000);
    peek_status(stat);
    checkOutput("final_status", stat, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
